id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipe, directly downstream of the register file.
//  Latches register-file read data, immediate and decoded control for EX.
//  Bypasses same-cycle WB writes (the regfile writes on posedge and reads combinationally).
//  Detects load-use hazards, inserts bubbles on stall/flush and counts them.
// PARAMETERS
//  DATA_W   32  datapath width
//  CTRL_W   10  packed control bundle width (field layout in mips_pipe_pkg)
//  CNT_W    16  width of saturating bubble counter
// PORTS
//  clk           in   1       rising-edge clock, the single clock
//  reset         in   1       synchronous, active-low; sampled on posedge clk
//  id_valid      in   1       ID holds a real instruction
//  id_rs         in   5       rs address (same as regfile rs)
//  id_rt         in   5       rt address
//  id_rd         in   5       rd address
//  id_uses_rt    in   1       instruction reads rt (R-type, beq, sw)
//  id_rsdata     in   DATA_W  regfile rsdata
//  id_rtdata     in   DATA_W  regfile rtdata
//  id_imm        in   DATA_W  sign-extended immediate
//  id_ctrl       in   CTRL_W  {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp[3:0]}
//  wb_RegWrite   in   1       WB write enable (same net driving regfile RegWrite)
//  wb_RdOrRt     in   5       WB destination (same net driving regfile RdOrRt)
//  wb_WriteData  in   DATA_W  WB data (same net driving regfile WriteData)
//  flush         in   1       taken branch/jump resolved in EX; kill ID instruction
//  stall         out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid      out  1       EX holds a real instruction
//  ex_rs, ex_rt  out  5 each  latched source addresses (for EX forwarding)
//  ex_dst        out  5       RegDst ? id_rd : id_rt, resolved at latch
//  ex_rsdata     out  DATA_W  latched rs operand
//  ex_rtdata     out  DATA_W  latched rt operand
//  ex_imm        out  DATA_W  latched immediate
//  ex_ctrl       out  CTRL_W  latched control; all-zero for a bubble
//  bubble_count  out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): every ex_* output 0, ex_valid 0, bubble_count 0. Reset overrides flush/stall.
//  - Latency: one cycle, ID inputs at edge N appear on ex_* after edge N.
//  - load_use = id_valid & ex_valid & ex_ctrl.MemRead & (ex_dst!=0)
//      & ((ex_dst==id_rs) | (id_uses_rt & (ex_dst==id_rt))).
//  - stall = load_use & ~flush. Stall is 0 while reset is asserted.
//  - Priority at each posedge: reset > flush > load_use > normal.
//  - flush or load_use inserts a bubble: ex_valid<=0, ex_ctrl<=0; other ex_* fields hold their previous value.
//    bubble_count += 1, saturating at 2^CNT_W-1.
//  - Normal cycle: all fields latch, ex_valid<=id_valid. If id_valid==0, ex_ctrl<=0 and no count.
//  - WB bypass applies only when wb_RegWrite & (wb_RdOrRt!=0):
//      wb_RdOrRt==id_rs -> ex_rsdata<=wb_WriteData.
//      wb_RdOrRt==id_rt -> ex_rtdata<=wb_WriteData. Both may hit simultaneously.
//    Otherwise the regfile data is latched. No bypass occurs for $0.
//  - A load-use stall lasts exactly one cycle: the bubble clears ex MemRead. Back-to-back loads re-evaluate each cycle.
//  - flush coincident with load_use: one bubble only, counted once, stall=0.
// STRUCTURE
//  - mips_pipe_pkg: CTRL_W, control bit indices (CTRL_REGWRITE..CTRL_ALUOP_LSB) and ALUOp encodings, shared with decode/EX.
//  - Sub-module load_use_detect (combinational): ex_valid, ex_MemRead, ex_dst, id_* -> load_use.
//  - Bypass muxes and pipeline flops stay in id_ex_stage.
// TESTING
//  1 Reset: hold reset=0 for 2 clk with random inputs -> all ex_* 0, stall 0, bubble_count 0.
//  2 Pass-through: id rs=3, rt=4, rd=5, RegDst=1, rsdata=0x11, rtdata=0x22 -> next cycle ex_dst=5, ex_rsdata=0x11, ex_rtdata=0x22, ex_valid=1.
//  3 WB bypass: id_rs=id_rt=7, wb_RegWrite=1, wb_RdOrRt=7, wb_WriteData=0xDEAD -> ex_rsdata=ex_rtdata=0xDEAD.
//    Repeat with wb_RdOrRt=0 -> the regfile values are latched.
//  4 Load-use: lw $8 in EX (MemRead=1, ex_dst=8), ID add rs=8 -> stall=1 for one cycle, bubble (ex_ctrl=0), bubble_count=1.
//    Next cycle stall=0 and the add latches.
//  5 Flush+load-use same cycle -> stall=0, single bubble, bubble_count increments by 1.
//    Flush alone with id_valid=1 -> ex_valid=0.
//  6 Saturation with CNT_W=2: 5 consecutive flushes -> bubble_count 1,2,3,3,3.
//    Mid-stall reset=0 -> all cleared next edge.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipe: control bundle layout and ALUOp codes.
// Decode packs the bundle, ID/EX latches it, EX unpacks it.
package mips_pipe_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,ALUOp[3:0]}
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_ALUOP_MSB = 3;
  localparam int CTRL_ALUOP_LSB = 0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9,
    ALU_LUI  = 4'd10,
    ALU_FUNC = 4'd15
  } alu_op_e;

  function automatic logic ctrl_mem_read(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_MEMREAD];
  endfunction

  function automatic logic ctrl_reg_dst(input logic [CTRL_W-1:0] ctrl);
    return ctrl[CTRL_REGDST];
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: a load sitting in EX whose destination is read by the ID instruction.
// $0 never creates a hazard because it is hard-wired to zero.
module load_use_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic dst_nonzero_s;
  logic rs_hit_s;
  logic rt_hit_s;

  assign dst_nonzero_s = (ex_dst != 5'd0);
  assign rs_hit_s      = (ex_dst == id_rs);
  assign rt_hit_s      = id_uses_rt & (ex_dst == id_rt);

  assign load_use = id_valid & ex_valid & ex_mem_read & dst_nonzero_s & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches operands/control for EX, bypasses same-cycle WB writes,
// turns load-use hazards and flushes into counted bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rsdata,
  input  logic [DATA_W-1:0] id_rtdata,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_RegWrite,
  input  logic [4:0]        wb_RdOrRt,
  input  logic [DATA_W-1:0] wb_WriteData,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [DATA_W-1:0] ex_rsdata,
  output logic [DATA_W-1:0] ex_rtdata,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  import mips_pipe_pkg::*;

  logic              load_use_s;
  logic              bubble_s;
  logic              wb_live_s;
  logic [DATA_W-1:0] rs_fwd_s;
  logic [DATA_W-1:0] rt_fwd_s;
  logic [4:0]        dst_sel_s;

  load_use_detect u_load_use_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_dst      (ex_dst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use_s)
  );

  // A flush already kills the ID instruction, so it must not also freeze the front end.
  assign stall    = reset & load_use_s & ~flush;
  assign bubble_s = flush | load_use_s;

  // The regfile writes on the same edge we latch, so its read data is stale for the WB target.
  always_comb begin
    wb_live_s = wb_RegWrite & (wb_RdOrRt != 5'd0);
    rs_fwd_s  = id_rsdata;
    rt_fwd_s  = id_rtdata;
    dst_sel_s = id_rt;
    if (wb_live_s && (wb_RdOrRt == id_rs)) begin
      rs_fwd_s = wb_WriteData;
    end else begin
      rs_fwd_s = id_rsdata;
    end
    if (wb_live_s && (wb_RdOrRt == id_rt)) begin
      rt_fwd_s = wb_WriteData;
    end else begin
      rt_fwd_s = id_rtdata;
    end
    if (id_ctrl[CTRL_REGDST]) begin
      dst_sel_s = id_rd;
    end else begin
      dst_sel_s = id_rt;
    end
  end

  // Pipeline register and saturating bubble counter; bubbles keep data fields, only kill valid/ctrl.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_rs        <= 5'd0;
      ex_rt        <= 5'd0;
      ex_dst       <= 5'd0;
      ex_rsdata    <= {DATA_W{1'b0}};
      ex_rtdata    <= {DATA_W{1'b0}};
      ex_imm       <= {DATA_W{1'b0}};
      ex_ctrl      <= {CTRL_W{1'b0}};
      bubble_count <= {CNT_W{1'b0}};
    end else if (bubble_s) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= {CTRL_W{1'b0}};
      if (bubble_count != {CNT_W{1'b1}}) begin
        bubble_count <= bubble_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        bubble_count <= bubble_count;
      end
    end else begin
      ex_valid  <= id_valid;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_dst    <= dst_sel_s;
      ex_rsdata <= rs_fwd_s;
      ex_rtdata <= rt_fwd_s;
      ex_imm    <= id_imm;
      if (id_valid) begin
        ex_ctrl <= id_ctrl;
      end else begin
        ex_ctrl <= {CTRL_W{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver pushes model predictions, a monitor pops and compares.
// A second instance with a 2-bit counter exercises bubble-count saturation on the same stimulus.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int CW = 10;

  localparam logic [CW-1:0] C_REGWRITE = 10'h200;
  localparam logic [CW-1:0] C_MEMREAD  = 10'h100;
  localparam logic [CW-1:0] C_MEMTOREG = 10'h040;
  localparam logic [CW-1:0] C_ALUSRC   = 10'h020;
  localparam logic [CW-1:0] C_REGDST   = 10'h010;

  logic          clk = 1'b0;
  logic          reset, id_valid, id_uses_rt, wb_RegWrite, flush;
  logic [4:0]    id_rs, id_rt, id_rd, wb_RdOrRt;
  logic [DW-1:0] id_rsdata, id_rtdata, id_imm, wb_WriteData;
  logic [CW-1:0] id_ctrl;

  logic          stall, ex_valid;
  logic [4:0]    ex_rs, ex_rt, ex_dst;
  logic [DW-1:0] ex_rsdata, ex_rtdata, ex_imm;
  logic [CW-1:0] ex_ctrl;
  logic [15:0]   bubble_count;

  logic          s_stall, s_ex_valid;
  logic [4:0]    s_ex_rs, s_ex_rt, s_ex_dst;
  logic [DW-1:0] s_ex_rsdata, s_ex_rtdata, s_ex_imm;
  logic [CW-1:0] s_ex_ctrl;
  logic [1:0]    s_bubble_count;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_RegWrite(wb_RegWrite), .wb_RdOrRt(wb_RdOrRt), .wb_WriteData(wb_WriteData),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_rsdata(ex_rsdata), .ex_rtdata(ex_rtdata), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rt(id_uses_rt), .id_rsdata(id_rsdata), .id_rtdata(id_rtdata), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .wb_RegWrite(wb_RegWrite), .wb_RdOrRt(wb_RdOrRt), .wb_WriteData(wb_WriteData),
    .flush(flush), .stall(s_stall), .ex_valid(s_ex_valid), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
    .ex_dst(s_ex_dst), .ex_rsdata(s_ex_rsdata), .ex_rtdata(s_ex_rtdata), .ex_imm(s_ex_imm),
    .ex_ctrl(s_ex_ctrl), .bubble_count(s_bubble_count)
  );

  typedef struct packed {
    logic          valid;
    logic [4:0]    rs, rt, dst;
    logic [DW-1:0] rsdata, rtdata, imm;
    logic [CW-1:0] ctrl;
    logic [15:0]   cnt;
    logic [1:0]    cnt2;
  } mstate_t;

  typedef struct packed {
    logic    stall;
    mstate_t s;
  } item_t;

  mstate_t m;
  item_t   sb[$];
  int      tests = 0;
  int      fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urt, input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                        input logic [CW-1:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
    id_rsdata = rsd; id_rtdata = rtd; id_imm = $urandom; id_ctrl = ctrl;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [DW-1:0] d);
    wb_RegWrite = we; wb_RdOrRt = rd; wb_WriteData = d;
  endtask

  task automatic rand_inputs();
    logic [CW-1:0] c;
    c = CW'($urandom);
    if ($urandom_range(0, 2) == 0) c = c | C_MEMREAD;
    set_id(($urandom_range(0, 6) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, c);
    set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
  endtask

  // Predict stall for the current inputs and the state after the coming edge, then advance one clock.
  task automatic issue();
    item_t it;
    logic  lu;
    lu = id_valid && m.valid && m.ctrl[8] && (m.dst != 5'd0) &&
         ((m.dst == id_rs) || (id_uses_rt && (m.dst == id_rt)));
    it.stall = reset && lu && !flush;
    if (!reset) begin
      m = '0;
    end else if (flush || lu) begin
      m.valid = 1'b0;
      m.ctrl  = '0;
      if (m.cnt != 16'hFFFF) m.cnt = m.cnt + 16'd1;
      if (m.cnt2 != 2'd3) m.cnt2 = m.cnt2 + 2'd1;
    end else begin
      m.valid  = id_valid;
      m.rs     = id_rs;
      m.rt     = id_rt;
      m.dst    = id_ctrl[4] ? id_rd : id_rt;
      m.rsdata = (wb_RegWrite && wb_RdOrRt != 5'd0 && wb_RdOrRt == id_rs) ? wb_WriteData : id_rsdata;
      m.rtdata = (wb_RegWrite && wb_RdOrRt != 5'd0 && wb_RdOrRt == id_rt) ? wb_WriteData : id_rtdata;
      m.imm    = id_imm;
      m.ctrl   = id_valid ? id_ctrl : '0;
    end
    it.s = m;
    sb.push_back(it);
    @(posedge clk);
    #2;
  endtask

  // Monitor: stall checked mid-cycle before the edge, registered outputs just after it.
  initial begin
    item_t cur;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        cur = sb[0];
        chk("stall", 64'(stall), 64'(cur.stall));
        chk("sat_stall", 64'(s_stall), 64'(cur.stall));
        @(posedge clk);
        #1;
        cur = sb.pop_front();
        chk("ex_valid", 64'(ex_valid), 64'(cur.s.valid));
        chk("ex_rs", 64'(ex_rs), 64'(cur.s.rs));
        chk("ex_rt", 64'(ex_rt), 64'(cur.s.rt));
        chk("ex_dst", 64'(ex_dst), 64'(cur.s.dst));
        chk("ex_rsdata", 64'(ex_rsdata), 64'(cur.s.rsdata));
        chk("ex_rtdata", 64'(ex_rtdata), 64'(cur.s.rtdata));
        chk("ex_imm", 64'(ex_imm), 64'(cur.s.imm));
        chk("ex_ctrl", 64'(ex_ctrl), 64'(cur.s.ctrl));
        chk("bubble_count", 64'(bubble_count), 64'(cur.s.cnt));
        chk("sat_ex_valid", 64'(s_ex_valid), 64'(cur.s.valid));
        chk("sat_ex_ctrl", 64'(s_ex_ctrl), 64'(cur.s.ctrl));
        chk("sat_bubble_count", 64'(s_bubble_count), 64'(cur.s.cnt2));
      end
    end
  end

  initial begin
    m = '0;
    reset = 1'b0; flush = 1'b0;
    rand_inputs();
    @(posedge clk);
    #2;

    // Reset with random inputs
    rand_inputs(); reset = 1'b0; flush = 1'($urandom); issue();
    rand_inputs(); reset = 1'b0; flush = 1'($urandom); issue();
    reset = 1'b1; flush = 1'b0;

    // Pass-through with RegDst
    set_wb(1'b0, 5'd0, 32'd0);
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 32'h11, 32'h22, C_REGWRITE | C_REGDST); issue();

    // WB bypass on both operands, then the $0 case
    set_id(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 32'hA, 32'hB, C_REGWRITE | C_REGDST);
    set_wb(1'b1, 5'd7, 32'hDEAD); issue();
    set_wb(1'b1, 5'd0, 32'hDEAD); issue();
    set_wb(1'b0, 5'd0, 32'd0);

    // lw $8 then dependent add: one stall, then the add latches
    set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 32'h100, 32'h0, C_REGWRITE | C_MEMREAD | C_MEMTOREG | C_ALUSRC); issue();
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h5, 32'h6, C_REGWRITE | C_REGDST); issue();
    issue();

    // Flush coincident with load-use, then flush alone
    set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 32'h100, 32'h0, C_REGWRITE | C_MEMREAD | C_MEMTOREG | C_ALUSRC); issue();
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h5, 32'h6, C_REGWRITE | C_REGDST); flush = 1'b1; issue();
    set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h7, 32'h8, C_REGWRITE | C_REGDST); issue();
    flush = 1'b0;

    // Fresh counter, five flushes to saturate the 2-bit counter
    reset = 1'b0; issue(); reset = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 5; i++) issue();
    flush = 1'b0;

    // Reset asserted during a load-use stall
    set_id(1'b1, 5'd2, 5'd8, 5'd0, 1'b0, 32'h100, 32'h0, C_REGWRITE | C_MEMREAD | C_MEMTOREG | C_ALUSRC); issue();
    set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 32'h5, 32'h6, C_REGWRITE | C_REGDST); reset = 1'b0; issue();
    reset = 1'b1; issue();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      reset = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 9) == 0);
      issue();
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d scoreboard entries left, expected 0", sb.size());
    end
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
